// File: rtl/sie_defs_pkg.sv
// SIE-level protocol constants shared by the packet engines.
// Ports: none (package).
package sie_defs_pkg;

  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;

endpackage

// File: rtl/usb_pe_pkg.sv
// Shared packet-engine types: handshake result encoding and FSM state.
// Ports: none (package).
package usb_pe_pkg;

  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_ACK  = 2'd1,
    RES_NAK  = 2'd2
  } pe_result_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PID,
    ST_DATA,
    ST_DECIDE
  } pe_state_t;

endpackage

// File: rtl/usb_pe_out_router_if.sv
// SIE receive byte stream toward the OUT router.
// master: SIE side (drives bytes, last flag, valid, CRC verdict).
// slave : router side (drives rxAcceptNewData ready).
interface usb_pe_out_router_if;

  logic       rxAcceptNewData;
  logic [7:0] rxData;
  logic       rxIsLastByte;
  logic       rxDataValid;
  logic       keepPacket;

  modport master (
    output rxData, rxIsLastByte, rxDataValid, keepPacket,
    input  rxAcceptNewData
  );

  modport slave (
    input  rxData, rxIsLastByte, rxDataValid, keepPacket,
    output rxAcceptNewData
  );

endinterface

// File: rtl/usb_pe_crc_strip.sv
// Two-entry delay line that holds back the trailing CRC16 bytes.
// Ports: clk48/rst, clear (empty the line), push (accept din),
//        full (two bytes held; the next push releases oldest), oldest.
module usb_pe_crc_strip #(
  parameter int unsigned DATA_WID = 8
) (
  input  logic                clk48,
  input  logic                rst,
  input  logic                clear,
  input  logic                push,
  input  logic [DATA_WID-1:0] din,
  output logic                full,
  output logic [DATA_WID-1:0] oldest
);

  logic [DATA_WID-1:0] line0;
  logic [DATA_WID-1:0] line1;
  logic [1:0]          fill;

  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      line0 <= '0;
      line1 <= '0;
      fill  <= '0;
    end else if (clear) begin
      fill <= '0;
    end else if (push) begin
      case (fill)
        2'd0:    line0 <= din;
        2'd1:    line1 <= din;
        default: begin
          line0 <= line1;
          line1 <= din;
        end
      endcase
      if (fill != 2'd2) fill <= fill + 2'd1;
    end
  end

  assign full   = (fill == 2'd2);
  assign oldest = line0;

endmodule

// File: rtl/usb_pe_out_router.sv
// OUT/SETUP data-stage router: checks the DATA PID against the endpoint
// toggle, streams payload into the selected endpoint FIFO (CRC stripped),
// and decides ACK/NAK/none with commit or rollback.
// Ports: clk48/rst; transStart/transEp/transIsSetup token info;
//        clearToggles; bus (SIE rx stream, slave modport);
//        EP_wrEn/EP_wrData/EP_commit/EP_rollback/EP_free FIFO side;
//        done/result/busy status.
// Optional: USB_PE_OUT_STATS_EN adds statCrcErr/statOverflow/statDup.
module usb_pe_out_router
  import sie_defs_pkg::*;
  import usb_pe_pkg::*;
#(
  parameter int unsigned ENDPOINTS   = 4,
  parameter int unsigned EP_ADDR_WID = 9,
  parameter int unsigned EP_DATA_WID = 8,
  localparam int unsigned EPW = (ENDPOINTS > 1) ? $clog2(ENDPOINTS) : 1,
  localparam int unsigned FW  = EP_ADDR_WID + 1
) (
  input  logic                       clk48,
  input  logic                       rst,
  input  logic                       transStart,
  input  logic [EPW-1:0]             transEp,
  input  logic                       transIsSetup,
  input  logic                       clearToggles,
  usb_pe_out_router_if.slave         bus,
  output logic [ENDPOINTS-1:0]       EP_wrEn,
  output logic [EP_DATA_WID-1:0]     EP_wrData,
  output logic [ENDPOINTS-1:0]       EP_commit,
  output logic [ENDPOINTS-1:0]       EP_rollback,
  input  logic [ENDPOINTS*FW-1:0]    EP_free,
  output logic                       done,
  output logic [1:0]                 result,
  output logic                       busy
`ifdef USB_PE_OUT_STATS_EN
  ,
  output logic [7:0]                 statCrcErr,
  output logic [7:0]                 statOverflow,
  output logic [7:0]                 statDup
`endif
);

  pe_state_t            state, state_nxt;
  logic [EPW-1:0]       ep_q;
  logic                 setup_q;
  logic [FW-1:0]        free_snap;
  logic [FW-1:0]        free_sel;
  logic [FW-1:0]        wr_cnt;
  logic [ENDPOINTS-1:0] toggle;
  logic [ENDPOINTS-1:0] ep_oh;
  logic                 pid_err, dup, ovf, keep_q;
  pe_result_t           res_q, res_c;
  logic                 accept, commit_c, rollback_c, tog_wr, tog_bit;
  logic                 strip_full, wr_try, wr_now, ovf_set;
  logic                 pid_ok, pid_tog, exp_tog;
  logic [EP_DATA_WID-1:0] strip_oldest;

  always_comb begin
    free_sel = '0;
    for (int unsigned i = 0; i < ENDPOINTS; i++)
      if (EPW'(i) == transEp) free_sel = EP_free[i*FW +: FW];
  end

  assign pid_ok  = (bus.rxData[3:0] == ~bus.rxData[7:4]) &&
                   (bus.rxData == PID_DATA0 || bus.rxData == PID_DATA1);
  assign pid_tog = (bus.rxData == PID_DATA1);
  assign exp_tog = setup_q ? 1'b0 : toggle[ep_q];
  assign ep_oh   = ENDPOINTS'(1) << ep_q;

  // A write is attempted whenever the line is full on a DATA handshake; once
  // the snapshot budget is used up the next attempt latches overflow instead.
  assign wr_try  = (state == ST_DATA) && bus.rxDataValid && strip_full &&
                   !pid_err && !dup && !ovf;
  assign wr_now  = wr_try && (wr_cnt != free_snap);
  assign ovf_set = wr_try && (wr_cnt == free_snap);

  usb_pe_crc_strip #(.DATA_WID(EP_DATA_WID)) u_strip (
    .clk48  (clk48),
    .rst    (rst),
    .clear  ((state == ST_IDLE) && transStart),
    .push   ((state == ST_DATA) && bus.rxDataValid),
    .din    (bus.rxData),
    .full   (strip_full),
    .oldest (strip_oldest)
  );

  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    done       = 1'b0;
    commit_c   = 1'b0;
    rollback_c = 1'b0;
    res_c      = res_q;
    tog_wr     = 1'b0;
    tog_bit    = 1'b0;
    case (state)
      ST_IDLE: if (transStart) state_nxt = ST_PID;
      ST_PID: begin
        accept = 1'b1;
        if (bus.rxDataValid) state_nxt = bus.rxIsLastByte ? ST_DECIDE : ST_DATA;
      end
      ST_DATA: begin
        accept = 1'b1;
        if (bus.rxDataValid && bus.rxIsLastByte) state_nxt = ST_DECIDE;
      end
      ST_DECIDE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
        // Line not full here means fewer than the two CRC bytes followed the PID.
        if (!keep_q || pid_err || !strip_full) begin
          res_c = RES_NONE; rollback_c = 1'b1;
        end else if (setup_q) begin
          if (ovf) begin
            res_c = RES_NONE; rollback_c = 1'b1;
          end else begin
            res_c = RES_ACK; commit_c = 1'b1; tog_wr = 1'b1; tog_bit = 1'b1;
          end
        end else if (ovf) begin
          res_c = RES_NAK; rollback_c = 1'b1;
        end else if (dup) begin
          res_c = RES_ACK; rollback_c = 1'b1;
        end else begin
          res_c = RES_ACK; commit_c = 1'b1; tog_wr = 1'b1; tog_bit = ~toggle[ep_q];
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      ep_q      <= '0;
      setup_q   <= 1'b0;
      free_snap <= '0;
      wr_cnt    <= '0;
      pid_err   <= 1'b0;
      dup       <= 1'b0;
      ovf       <= 1'b0;
      keep_q    <= 1'b0;
      res_q     <= RES_NONE;
      toggle    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (transStart) begin
          ep_q      <= transEp;
          setup_q   <= transIsSetup;
          free_snap <= free_sel;
          wr_cnt    <= '0;
          pid_err   <= 1'b0;
          dup       <= 1'b0;
          ovf       <= 1'b0;
          keep_q    <= 1'b0;
        end
        ST_PID: if (bus.rxDataValid) begin
          pid_err <= !pid_ok;
          dup     <= (pid_tog != exp_tog);
          if (bus.rxIsLastByte) keep_q <= bus.keepPacket;
        end
        ST_DATA: if (bus.rxDataValid) begin
          if (wr_now)           wr_cnt <= wr_cnt + FW'(1);
          if (ovf_set)          ovf    <= 1'b1;
          if (bus.rxIsLastByte) keep_q <= bus.keepPacket;
        end
        ST_DECIDE: res_q <= res_c;
        default: ;
      endcase
      if (clearToggles) toggle <= '0;
      else if (tog_wr)  toggle[ep_q] <= tog_bit;
    end
  end

`ifdef USB_PE_OUT_STATS_EN
  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      statCrcErr   <= '0;
      statOverflow <= '0;
      statDup      <= '0;
    end else if (state == ST_DECIDE) begin
      if (!keep_q && statCrcErr   != 8'hFF) statCrcErr   <= statCrcErr + 8'd1;
      if (ovf     && statOverflow != 8'hFF) statOverflow <= statOverflow + 8'd1;
      if (dup     && statDup      != 8'hFF) statDup      <= statDup + 8'd1;
    end
  end
`endif

  assign bus.rxAcceptNewData = accept;
  assign EP_wrEn     = wr_now ? ep_oh : '0;
  assign EP_wrData   = wr_now ? strip_oldest : '0;
  assign EP_commit   = commit_c ? ep_oh : '0;
  assign EP_rollback = rollback_c ? ep_oh : '0;
  assign result      = res_c;
  assign busy        = (state != ST_IDLE);

endmodule
